// File: rtl/cpu_stepper_pkg.sv
// Shared definitions for the instruction-cycle sequencer: phase encodings,
// legal step-count range and the phase-to-strobe decode.
package cpu_stepper_pkg;

    localparam int unsigned NSTEPS_MIN = 2;
    localparam int unsigned NSTEPS_MAX = 8;
    localparam int unsigned PHASE_W    = 3;

    typedef enum logic [PHASE_W-1:0] {
        IDLE = 3'd0,
        P0   = 3'd1,
        P1   = 3'd2,
        P2   = 3'd3,
        P3   = 3'd4
    } phase_e;

    typedef struct packed {
        logic clke;
        logic clks;
    } strobe_t;

    // clks sits strictly inside the clke window: P0/P2 enable only, P1 both
    function automatic strobe_t phase_strobes(input phase_e ph);
        strobe_t s;
        s = '0;
        case (ph)
            P0:      s.clke = 1'b1;
            P1:      begin s.clke = 1'b1; s.clks = 1'b1; end
            P2:      s.clke = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/cpu_stepper_phase.sv
// Five-state phase FSM (IDLE, P0..P3) with registered clke/clks and a
// combinational adv_c strobe marking the P3->P0 transition.
module cpu_stepper_phase
    import cpu_stepper_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic go,
    output logic clke,
    output logic clks,
    output logic adv_c
);

    phase_e  state;
    phase_e  state_nxt;
    logic    paused;
    logic    paused_nxt;
    strobe_t strobe_nxt;

    // State register; strobes are registered from the next-state decode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            paused <= 1'b0;
            clke   <= 1'b0;
            clks   <= 1'b0;
        end else begin
            state  <= state_nxt;
            paused <= paused_nxt;
            clke   <= strobe_nxt.clke;
            clks   <= strobe_nxt.clks;
        end
    end

    // A frozen phase is re-presented for one edge on resume before advancing
    always_comb begin
        state_nxt  = state;
        paused_nxt = paused;
        adv_c      = 1'b0;
        if (!run) begin
            if (state != IDLE) paused_nxt = 1'b1;
        end else begin
            paused_nxt = 1'b0;
            case (state)
                IDLE: state_nxt = P0;
                P0:   if (!paused) state_nxt = P1;
                P1:   if (!paused) state_nxt = P2;
                P2:   if (!paused) state_nxt = P3;
                P3: begin
                    if (go) begin
                        state_nxt = P0;
                        adv_c     = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Strobes drop while frozen
    always_comb begin
        strobe_nxt = '0;
        if (run) strobe_nxt = phase_strobes(state_nxt);
    end

endmodule

// File: rtl/cpu_stepper.sv
// Instruction-cycle sequencer top: one-hot step ring, step_clr mux and
// cycle_done pulse around the phase FSM. SINGLE_STEP_EN adds step_go gating.
module cpu_stepper
    import cpu_stepper_pkg::*;
#(
    parameter int unsigned NSTEPS = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step_clr,
`ifdef SINGLE_STEP_EN
    input  logic              step_go,
`endif
    output logic              clke,
    output logic              clks,
    output logic [NSTEPS-1:0] step,
    output logic              cycle_done
);

    if (NSTEPS < NSTEPS_MIN || NSTEPS > NSTEPS_MAX) begin : g_bad_nsteps
        $error("cpu_stepper: NSTEPS out of range");
    end

    logic              go;
    logic              adv_c;
    logic [NSTEPS-1:0] step_rot;

`ifdef SINGLE_STEP_EN
    assign go = step_go;
`else
    assign go = 1'b1;
`endif

    cpu_stepper_phase u_phase (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .go    (go),
        .clke  (clke),
        .clks  (clks),
        .adv_c (adv_c)
    );

    assign step_rot = {step[NSTEPS-2:0], step[NSTEPS-1]};

    // Step ring advances only on P3->P0; a wrap and a clear give one pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step       <= NSTEPS'(1);
            cycle_done <= 1'b0;
        end else begin
            cycle_done <= 1'b0;
            if (adv_c) begin
                step       <= step_clr ? NSTEPS'(1) : step_rot;
                cycle_done <= step_clr | step[NSTEPS-1];
            end
        end
    end

endmodule

// File: tb/tb_cpu_stepper.sv
// Scoreboard bench for cpu_stepper: the driver queues the expected outputs
// of every edge, a negedge monitor pops and compares. Honours SINGLE_STEP_EN.
module tb_cpu_stepper;

    localparam int unsigned NSTEPS = 6;

    typedef struct packed {
        logic              clke;
        logic              clks;
        logic [NSTEPS-1:0] step;
        logic              done;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              run = 1'b0;
    logic              step_clr = 1'b0;
    logic              step_go = 1'b1;
    logic              clke;
    logic              clks;
    logic [NSTEPS-1:0] step;
    logic              cycle_done;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   k = -1;
    logic paused = 1'b0;

    cpu_stepper #(.NSTEPS(NSTEPS)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .step_clr   (step_clr),
`ifdef SINGLE_STEP_EN
        .step_go    (step_go),
`endif
        .clke       (clke),
        .clks       (clks),
        .step       (step),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input exp_t act, input exp_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got clke=%b clks=%b step=%b done=%b, expected clke=%b clks=%b step=%b done=%b",
                     name, act.clke, act.clks, act.step, act.done,
                     exp.clke, exp.clks, exp.step, exp.done);
        end
    endtask

    function automatic exp_t sample();
        exp_t a;
        a.clke = clke;
        a.clks = clks;
        a.step = step;
        a.done = cycle_done;
        return a;
    endfunction

    // Expected outputs for phase kk%4 of step (kk/4)%NSTEPS
    function automatic exp_t expect_at(input int kk, input logic done);
        exp_t e;
        int   ph;
        ph     = kk % 4;
        e.clke = (ph != 3);
        e.clks = (ph == 1);
        e.step = NSTEPS'(1) << ((kk / 4) % NSTEPS);
        e.done = done;
        return e;
    endfunction

    function automatic exp_t reset_vals();
        exp_t e;
        e.clke = 1'b0;
        e.clks = 1'b0;
        e.step = NSTEPS'(1);
        e.done = 1'b0;
        return e;
    endfunction

    // Drive one edge and queue what the outputs must be right after it
    task automatic tick(input logic r, input logic clr, input logic go);
        exp_t e;
        logic done;
        done     = 1'b0;
        run      = r;
        step_clr = clr;
        step_go  = go;
        if (!reset) begin
            k      = -1;
            paused = 1'b0;
            e      = reset_vals();
        end else if (!r) begin
            if (k >= 0) begin
                paused = 1'b1;
                e      = expect_at(k, 1'b0);
                e.clke = 1'b0;
                e.clks = 1'b0;
            end else begin
                e = reset_vals();
            end
        end else if (k < 0) begin
            k = 0;
            e = expect_at(k, 1'b0);
        end else if (paused && (k % 4 != 3)) begin
            paused = 1'b0;
            e      = expect_at(k, 1'b0);
        end else begin
            paused = 1'b0;
            if (k % 4 == 3) begin
                if (go) begin
                    k    = clr ? 0 : k + 1;
                    done = ((k / 4) % NSTEPS == 0);
                end
            end else begin
                k = k + 1;
            end
            e = expect_at(k, done);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic tick_until(input int target);
        for (int n = 0; n < 200 && k != target; n++) tick(1'b1, 1'b0, 1'b1);
        tests++;
        if (k != target) begin
            fails++;
            $display("FAIL reach_k: got %0d, expected %0d", k, target);
        end
    endtask

    task automatic lit(input string name, input logic [NSTEPS-1:0] s,
                       input logic ke, input logic ks, input logic d);
        exp_t e;
        e.clke = ke;
        e.clks = ks;
        e.step = s;
        e.done = d;
        check(name, sample(), e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("edge@%0t", $time), sample(), e);
        end
    end

    initial begin
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        lit("reset_hold", 6'b000001, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        // Free run: phase patterns and a full 1..6 walk with one wrap pulse
        for (int i = 0; i < 25; i++) tick(1'b1, 1'b0, 1'b1);
        lit("wrap_clk25", 6'b000001, 1'b1, 1'b0, 1'b1);

        // step_clr in P1 is ignored, in P3 forces step 1
        tick_until(29);
        tick(1'b1, 1'b1, 1'b1);
        lit("clr_in_p1", 6'b000010, 1'b1, 1'b0, 1'b0);
        tick_until(35);
        tick(1'b1, 1'b1, 1'b1);
        lit("clr_in_p3", 6'b000001, 1'b1, 1'b0, 1'b1);

        // Freeze for 5 clk in P1 of step 2, then resume
        tick_until(5);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1);
        lit("frozen_p1", 6'b000010, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        lit("resume_p1", 6'b000010, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1);
        lit("after_resume", 6'b000100, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of P2 of step 4
        tick_until(14);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("async_reset", sample(), reset_vals());
        tick(1'b1, 1'b0, 1'b1);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b1);

`ifdef SINGLE_STEP_EN
        // Park in P3 without step_go, then a single-clk pulse advances once
        tick_until(11);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0);
        lit("parked_p3", 6'b000100, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b0);
        lit("single_adv", 6'b001000, 1'b0, 1'b0, 1'b0);
`endif

        run = 1'b0;
        for (int n = 0; n < 10 && sb.size() > 0; n++) @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
